freeze_ctl_multi: RTL

- Avalon-MM CSR slave controlling freeze and region reset for NUM_REGIONS partial-reconfiguration regions.
- Successor to the fixed 4-register freeze block. Adds per-region freeze sequencing: drain handshake with the region, programmable timeout, sticky status, and a timed region reset pulse.
- Sits between the host CSR interconnect and the PR region wrappers, all on one clock.

---
 rtl/freeze_ctl_multi.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/freeze_ctl_multi.sv
// freeze_ctl_multi: CSR-driven freeze/drain/reset sequencer for NUM_REGIONS PR regions.
// Optional timeout interrupt enabled by defining FREEZE_CTL_IRQ_EN.
module freeze_ctl_multi #(
    parameter int          WIDTH           = 32,
    parameter int          NUM_REGIONS     = 4,
    parameter int          DEFAULT_TIMEOUT = 1024,
    parameter int          RESET_CYCLES    = 16,
    parameter logic [31:0] VERSION         = 32'h0002_0000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [2:0]             slave_address,
    input  logic [WIDTH-1:0]       slave_writedata,
    input  logic                   slave_read,
    input  logic                   slave_write,
    input  logic [WIDTH/8-1:0]     slave_byteenable,
    output logic [WIDTH-1:0]       slave_readdata,
    output logic                   slave_readdatavalid,
    output logic                   slave_waitrequest,
    input  logic [NUM_REGIONS-1:0] region_idle,
    output logic [NUM_REGIONS-1:0] freeze,
    output logic [NUM_REGIONS-1:0] region_resetn,
    output logic                   irq
);
    localparam int N  = NUM_REGIONS;
    localparam int PW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, FROZEN, RESETTING} state_t;

    state_t         st_q [N];
    state_t         st_d [N];
    logic [31:0]    cnt_q [N];
    logic [31:0]    cnt_d [N];
    logic [PW-1:0]  pc_q [N];
    logic [PW-1:0]  pc_d [N];

    logic [N-1:0]   ctrl_q, ctrl_d;
    logic [N-1:0]   tflag_q, tflag_d;
    logic [N-1:0]   tset, rst_req, w1c, frozen, mask_rd;
    logic [31:0]    tmo_q, wmask, rd_mux;
    logic [31:0]    rdata_q;
    logic           rvalid_q;
    logic           wr_ctrl, wr_stat, wr_tmo, wr_rst;

    assign slave_waitrequest   = 1'b0;
    assign slave_readdata      = rdata_q;
    assign slave_readdatavalid = rvalid_q;

    assign wmask = {{8{slave_byteenable[3]}}, {8{slave_byteenable[2]}},
                    {8{slave_byteenable[1]}}, {8{slave_byteenable[0]}}};

    assign wr_ctrl = slave_write && (slave_address == 3'd0);
    assign wr_stat = slave_write && (slave_address == 3'd1);
    assign wr_tmo  = slave_write && (slave_address == 3'd2);
    assign wr_rst  = slave_write && (slave_address == 3'd3);

    // Decode the CSR write of this cycle; FSMs act on it at the same edge.
    always_comb begin
        ctrl_d  = ctrl_q;
        rst_req = '0;
        w1c     = '0;
        if (wr_ctrl)
            ctrl_d = (ctrl_q & ~wmask[N-1:0]) |
                     (slave_writedata[N-1:0] & wmask[N-1:0]);
        if (wr_rst)
            rst_req = slave_writedata[N-1:0] & wmask[N-1:0];
        if (wr_stat)
            w1c = slave_writedata[16 +: N] & wmask[16 +: N];
        tflag_d = (tflag_q & ~w1c) | tset;
    end

    // Per-region state, drain counter and reset-pulse counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                st_q[i]  <= RUN;
                cnt_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                pc_q[i]  <= pc_d[i];
            end
        end
    end

    // Next-state: idle beats timeout; a running pulse always completes.
    always_comb begin
        tset = '0;
        for (int i = 0; i < N; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            pc_d[i]  = pc_q[i];
            unique case (st_q[i])
                RUN: begin
                    if (ctrl_d[i]) begin
                        st_d[i]  = DRAIN;
                        cnt_d[i] = '0;
                    end
                end
                DRAIN: begin
                    cnt_d[i] = cnt_q[i] + 32'd1;
                    if (!ctrl_d[i])
                        st_d[i] = RUN;
                    else if (region_idle[i])
                        st_d[i] = FROZEN;
                    else if (tmo_q != 32'd0 && cnt_q[i] == tmo_q - 32'd1) begin
                        st_d[i] = FROZEN;
                        tset[i] = 1'b1;
                    end
                end
                FROZEN: begin
                    if (rst_req[i]) begin
                        st_d[i] = RESETTING;
                        pc_d[i] = PW'(RESET_CYCLES - 1);
                    end else if (!ctrl_d[i]) begin
                        st_d[i] = RUN;
                    end
                end
                RESETTING: begin
                    if (pc_q[i] == '0)
                        st_d[i] = FROZEN;
                    else
                        pc_d[i] = pc_q[i] - PW'(1);
                end
            endcase
        end
    end

    // Region outputs decoded straight from state so reset clears them at once.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            freeze[i]        = (st_q[i] != RUN);
            region_resetn[i] = (st_q[i] != RESETTING);
            frozen[i]        = (st_q[i] == FROZEN);
        end
    end

    // CSR storage: control, sticky timeout flags, timeout limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_q  <= '0;
            tflag_q <= '0;
            tmo_q   <= 32'(DEFAULT_TIMEOUT);
        end else begin
            ctrl_q  <= ctrl_d;
            tflag_q <= tflag_d;
            if (wr_tmo)
                tmo_q <= (tmo_q & ~wmask) | (slave_writedata & wmask);
        end
    end

`ifdef FREEZE_CTL_IRQ_EN
    logic [N-1:0] mask_q;
    logic         irq_q;

    // Interrupt mask and registered level interrupt.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (slave_write && slave_address == 3'd4)
                mask_q <= (mask_q & ~wmask[N-1:0]) |
                          (slave_writedata[N-1:0] & wmask[N-1:0]);
            irq_q <= |(tflag_q & mask_q);
        end
    end

    assign mask_rd = mask_q;
    assign irq     = irq_q;
`else
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

    // Read mux; unimplemented bits read as zero.
    always_comb begin
        rd_mux = '0;
        unique case (slave_address)
            3'd0: rd_mux[N-1:0]    = ctrl_q;
            3'd1: begin
                rd_mux[N-1:0]      = frozen;
                rd_mux[16 +: N]    = tflag_q;
            end
            3'd2: rd_mux           = tmo_q;
            3'd4: rd_mux[N-1:0]    = mask_rd;
            3'd5: rd_mux           = VERSION;
            default: rd_mux        = '0;
        endcase
    end

    // Read data captured in the strobe cycle, valid on the next.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= slave_read;
            if (slave_read)
                rdata_q <= rd_mux;
        end
    end
endmodule
